bit_ser_operand_feeder: RTL and testbench
=========================================

# bit_ser_operand_feeder

Upstream stage of the bit-serial adder. Accepts two WIDTH-bit parallel operands over a valid/ready handshake. Clears the adder, then streams both operands LSB-first, one bit pair per clock, followed by one zero flush cycle so the final carry reaches the adder's MSB result bit. Drives the adder's A, B and clear inputs directly, so the adder no longer depends on hand-sequenced stimulus.

## Interface
- WIDTH, 8, operand width in bits; legal range 1..32.
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  feeder can accept an operand pair this cycle.
- in_a  input  WIDTH  operand A, parallel.
- in_b  input  WIDTH  operand B, parallel.
- ser_a  output  1  serial A bit to the adder's A input.
- ser_b  output  1  serial B bit to the adder's B input.
- bit_valid  output  1  ser_a/ser_b carry an operand bit; high during SHIFT only.
- bit_last  output  1  marks the operand MSB; high in the last SHIFT cycle only.
- adder_clr_n  output  1  active-low clear to the adder; low for exactly one cycle per operation.
- busy  output  1  high in any state other than IDLE.

## Operation
- The state machine has four states: IDLE, CLEAR, SHIFT and FLUSH.
- IDLE: in_ready=1.
  - If in_valid=1, capture in_a and in_b into shift registers sh_a/sh_b and go to CLEAR.
- CLEAR: adder_clr_n=0 and ser_a=ser_b=0. Load bit counter cnt=0. Go to SHIFT.
- SHIFT:
  - ser_a=sh_a[0], ser_b=sh_b[0] and bit_valid=1.
  - Each cycle, shift both registers right, zero-filled, and increment cnt.
  - bit_last=1 when cnt==WIDTH-1; after that cycle, go to FLUSH.
- FLUSH: ser_a=ser_b=0 and bit_valid=0, so the adder absorbs the final carry. Go to IDLE.
- Register widths:
  - cnt is $clog2(WIDTH+1) bits wide.
  - Shift registers are exactly WIDTH bits wide. There is no sign extension; operands are unsigned.
- in_valid is ignored outside IDLE; in_a and in_b are sampled only on the handshake edge.
- All outputs are registered.
- Reset asserted mid-operation:
  - the state returns to IDLE immediately and the shift registers clear;
  - no partial bits are emitted after release.
- The reset value of every output is 0, except in_ready=1 and adder_clr_n=1.
- WIDTH=1: SHIFT lasts one cycle, with bit_valid=1 and bit_last=1 in that same cycle.

## Timing
- Handshake at edge T:
  - CLEAR is visible in the cycle after T.
  - SHIFT runs T+2 through T+WIDTH+1.
  - FLUSH is at T+WIDTH+2.
  - IDLE (in_ready=1) is at T+WIDTH+3.
- Throughput without the skid buffer is one operation per WIDTH+3 cycles.
- The final adder result is valid at the edge ending FLUSH.
- Outputs change only on clk rising edges, except during asynchronous reset.

## Configuration
- FEEDER_SKID_EN: when defined, adds a one-entry operand holding buffer.
  - in_ready = !buf_full in every state.
  - An operand pair accepted while busy is stored in the buffer.
  - At the end of FLUSH, if the buffer is full, go directly to CLEAR with the buffered pair and empty the buffer. Throughput is one operation per WIDTH+2 cycles.
  - A simultaneous accept and drain in the FLUSH cycle is legal; the buffer stays full with the new pair.
- When not defined: there is no buffer, and in_ready is high only in IDLE.

## Structure
- Shared package bit_ser_pkg:
  - feeder_state_t enum (IDLE, CLEAR, SHIFT, FLUSH);
  - FEEDER_DEF_WIDTH=8;
  - function feeder_cycles(width) returning width+3.
- Sub-module piso_shreg: WIDTH-bit parallel-load, right-shift, zero-fill register with load/shift/clear inputs and an LSB output.
  - It is instantiated twice, once for A and once for B.
  - The top-level FSM, counter and optional skid buffer live in bit_ser_operand_feeder.

## Test plan
- Reset asserted, then released with in_valid=0: in_ready=1, busy=0, adder_clr_n=1, and bit_valid stays 0 for 20 cycles.
- in_a=7, in_b=3, feeding the adder → adder_clr_n pulses low for one cycle, then:
  - ser_a = 1,1,1,0,0,0,0,0 and ser_b = 1,1,0,0,0,0,0,0;
  - bit_last appears on the 8th bit;
  - adder result = 10 after FLUSH.
- in_a=255, in_b=1 → the adder result is 256 (9'b1_0000_0000), which checks that the flush carry lands in the MSB; in_ready returns 11 cycles after the handshake.
- in_valid held high in IDLE with the in_a value changed in SHIFT/FLUSH, and the second pair (6, 4) applied at the next IDLE:
  - the first operation is not corrupted by the mid-operation change;
  - the second operation outputs ser_a = 0,1,1,0…, ser_b = 0,0,1,0…, and the result is 10.
- clr_n dropped during the 4th SHIFT cycle → bit_valid=0, ser_a=ser_b=0 and in_ready=1 immediately. After release, a new pair 1+1 yields result 2.
- With FEEDER_SKID_EN defined, three back-to-back pairs (7,3), (6,4), (255,1) are accepted. The second and third CLEAR cycles follow FLUSH with no IDLE cycle between them, and the results are 10, 10, 256.

Source files
------------

// File: rtl/bit_ser_pkg.sv
// ---------------------------------------------------------------------------
// bit_ser_pkg : shared types and constants for the bit-serial adder datapath
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bit_ser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      SHIFT = 2'd2,
      FLUSH = 2'd3
   } feeder_state_t;

   localparam int FEEDER_DEF_WIDTH = 8;

   // Cycles from one handshake to the next when there is no holding buffer.
   function automatic int feeder_cycles(input int width);
      return width + 3;
   endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shreg.sv
// ---------------------------------------------------------------------------
// piso_shreg : parallel-load, right-shift, zero-fill register with LSB output
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module piso_shreg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             load,
   input  logic             shift,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic             lsb
);

   logic [WIDTH-1:0] sr;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sr <= '0;
      end else if (clear) begin
         sr <= '0;
      end else if (load) begin
         sr <= d;
      end else if (shift) begin
         sr <= sr >> 1;
      end
   end

   assign lsb = sr[0];

endmodule

`default_nettype wire

// File: rtl/bit_ser_operand_feeder.sv
// ---------------------------------------------------------------------------
// bit_ser_operand_feeder : clears the bit-serial adder, then streams two
// operands LSB-first plus one flush cycle. FEEDER_SKID_EN adds a one-entry
// operand holding buffer.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bit_ser_operand_feeder
   import bit_ser_pkg::*;
#(
   parameter int WIDTH = FEEDER_DEF_WIDTH
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             ser_a,
   output logic             ser_b,
   output logic             bit_valid,
   output logic             bit_last,
   output logic             adder_clr_n,
   output logic             busy
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   feeder_state_t    state;
   feeder_state_t    nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nx;
   logic             accept;
   logic             load;
   logic             shift;
   logic             clear;
   logic             rdy_nx;
   logic             lsb_a;
   logic             lsb_b;
   logic [WIDTH-1:0] ld_a;
   logic [WIDTH-1:0] ld_b;

   assign accept = in_valid & in_ready;
   // The registers shift on the CLEAR->SHIFT edge too, so the registered
   // serial bit always leads the register contents by one position.
   assign shift  = (state == CLEAR) || (state == SHIFT);
   assign clear  = (state == FLUSH) && !load;
   assign cnt_nx = (state == CLEAR) ? '0 : cnt + 1'b1;

`ifdef FEEDER_SKID_EN
   logic             buf_full;
   logic             buf_full_nx;
   logic             open_slot;
   logic             take_buf;
   logic             take_in;
   logic [WIDTH-1:0] buf_a;
   logic [WIDTH-1:0] buf_b;

   // A new operation may start from IDLE or straight out of FLUSH.
   assign open_slot   = (state == IDLE) || (state == FLUSH);
   assign take_buf    = open_slot && buf_full;
   assign take_in     = open_slot && !buf_full && accept;
   assign load        = take_buf | take_in;
   assign ld_a        = take_buf ? buf_a : in_a;
   assign ld_b        = take_buf ? buf_b : in_b;
   assign buf_full_nx = (buf_full && !take_buf) || (accept && !take_in);
   assign rdy_nx      = !buf_full_nx;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         buf_full <= 1'b0;
         buf_a    <= '0;
         buf_b    <= '0;
      end else begin
         buf_full <= buf_full_nx;
         if (accept && !take_in) begin
            buf_a <= in_a;
            buf_b <= in_b;
         end
      end
   end
`else
   assign load   = accept && (state == IDLE);
   assign ld_a   = in_a;
   assign ld_b   = in_b;
   assign rdy_nx = (nxt == IDLE);
`endif

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (load) nxt = CLEAR;
         CLEAR:   nxt = SHIFT;
         SHIFT:   if (cnt == LAST) nxt = FLUSH;
         FLUSH:   nxt = load ? CLEAR : IDLE;
         default: nxt = IDLE;
      endcase
   end

   piso_shreg #(.WIDTH(WIDTH)) u_sh_a (
      .clk   (clk),
      .clr_n (clr_n),
      .load  (load),
      .shift (shift),
      .clear (clear),
      .d     (ld_a),
      .lsb   (lsb_a)
   );

   piso_shreg #(.WIDTH(WIDTH)) u_sh_b (
      .clk   (clk),
      .clr_n (clr_n),
      .load  (load),
      .shift (shift),
      .clear (clear),
      .d     (ld_b),
      .lsb   (lsb_b)
   );

   // Outputs are decoded from the next state so they line up with it.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state       <= IDLE;
         cnt         <= '0;
         in_ready    <= 1'b1;
         busy        <= 1'b0;
         adder_clr_n <= 1'b1;
         bit_valid   <= 1'b0;
         bit_last    <= 1'b0;
         ser_a       <= 1'b0;
         ser_b       <= 1'b0;
      end else begin
         state       <= nxt;
         if (shift) begin
            cnt <= cnt_nx;
         end
         in_ready    <= rdy_nx;
         busy        <= (nxt != IDLE);
         adder_clr_n <= (nxt != CLEAR);
         bit_valid   <= (nxt == SHIFT);
         bit_last    <= (nxt == SHIFT) && (cnt_nx == LAST);
         ser_a       <= (nxt == SHIFT) && lsb_a;
         ser_b       <= (nxt == SHIFT) && lsb_b;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bit_ser_operand_feeder.sv
// ---------------------------------------------------------------------------
// tb_bit_ser_operand_feeder : directed bench with a serial-adder model
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bit_ser_operand_feeder;

   localparam int W = 8;

   logic         clk      = 1'b0;
   logic         clr_n    = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_a     = '0;
   logic [W-1:0] in_b     = '0;
   logic         in_ready;
   logic         ser_a;
   logic         ser_b;
   logic         bit_valid;
   logic         bit_last;
   logic         adder_clr_n;
   logic         busy;

   int n_vec = 0;
   int n_err = 0;
   int quiet;

   always #5 clk = ~clk;

   bit_ser_operand_feeder #(.WIDTH(W)) dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .ser_a       (ser_a),
      .ser_b       (ser_b),
      .bit_valid   (bit_valid),
      .bit_last    (bit_last),
      .adder_clr_n (adder_clr_n),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One full operation, checked cycle by cycle; a serial adder model sums the stream.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] exp_res, input logic hold,
                         input logic [W-1:0] na, input logic [W-1:0] nb);
      logic [W-1:0] sa, sb, vmask, lmask;
      logic [W:0]   res;
      logic         c;
      int           clr_low;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      for (int t = 0; t < 40 && !in_ready; t++) @(negedge clk);
      check({tag, ":ready"}, in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = hold;
      in_a     = 8'hAA;
      in_b     = 8'h55;
      @(negedge clk);
      check({tag, ":clear"}, {in_ready, adder_clr_n, bit_valid, ser_a, ser_b, busy}, 6'b000001);
      c = 1'b0; clr_low = 0; res = '0;
      sa = '0; sb = '0; vmask = '0; lmask = '0;
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         sa[k] = ser_a; sb[k] = ser_b; vmask[k] = bit_valid; lmask[k] = bit_last;
         if (!adder_clr_n) clr_low++;
         res[k] = ser_a ^ ser_b ^ c;
         c      = (ser_a & ser_b) | (c & (ser_a ^ ser_b));
      end
      check({tag, ":ser_a"}, sa, a);
      check({tag, ":ser_b"}, sb, b);
      check({tag, ":valid"}, vmask, 8'hFF);
      check({tag, ":last"}, lmask, 8'h80);
      check({tag, ":clr_once"}, clr_low, 0);
      @(negedge clk);
      check({tag, ":flush"}, {adder_clr_n, bit_valid, bit_last, ser_a, ser_b, busy}, 6'b100001);
      res[W] = c ^ ser_a ^ ser_b;
      check({tag, ":result"}, res, exp_res);
      if (hold) begin
         in_a = na;
         in_b = nb;
      end
      @(negedge clk);
      check({tag, ":idle"}, {in_ready, busy}, 2'b10);
   endtask

`ifdef FEEDER_SKID_EN
   logic [W-1:0] pa [3];
   logic [W-1:0] pb [3];
   logic [W:0]   er [3];
   logic [W:0]   mres;
   int           mgap;

   task automatic watch_op(output logic [W:0] res, output int gap);
      logic c;
      c   = 1'b0;
      res = '0;
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (adder_clr_n && gap < 60);
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         res[k] = ser_a ^ ser_b ^ c;
         c      = (ser_a & ser_b) | (c & (ser_a ^ ser_b));
      end
      @(negedge clk);
      res[W] = c ^ ser_a ^ ser_b;
   endtask
`endif

   initial begin
      #2 clr_n = 1'b0;
      #10;
      check("rst_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_clr_n", adder_clr_n, 1);
      check("rst_outs", {bit_valid, bit_last, ser_a, ser_b}, 4'b0000);
      @(negedge clk);
      clr_n = 1'b1;
      quiet = 0;
      repeat (20) begin
         @(negedge clk);
         if (bit_valid || busy || !in_ready) quiet++;
      end
      check("idle_20", quiet, 0);

`ifndef FEEDER_SKID_EN
      run_op("add7_3", 8'd7, 8'd3, 9'd10, 1'b0, 8'd0, 8'd0);
      run_op("add255_1", 8'd255, 8'd1, 9'd256, 1'b0, 8'd0, 8'd0);
      run_op("hold_1st", 8'd7, 8'd3, 9'd10, 1'b1, 8'd6, 8'd4);
      run_op("hold_2nd", 8'd6, 8'd4, 9'd10, 1'b0, 8'd0, 8'd0);

      in_valid = 1'b1;
      in_a     = 8'hFF;
      in_b     = 8'hFF;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_shift", bit_valid, 1);
      clr_n = 1'b0;
      #1;
      check("mid_rst", {bit_valid, ser_a, ser_b, in_ready, busy, adder_clr_n}, 6'b000101);
      @(negedge clk);
      clr_n = 1'b1;
      quiet = 0;
      repeat (12) begin
         @(negedge clk);
         if (bit_valid || busy || ser_a || ser_b) quiet++;
      end
      check("post_rst_quiet", quiet, 0);
      run_op("add1_1", 8'd1, 8'd1, 9'd2, 1'b0, 8'd0, 8'd0);
`else
      pa = '{8'd7, 8'd6, 8'd255};
      pb = '{8'd3, 8'd4, 8'd1};
      er = '{9'd10, 9'd10, 9'd256};
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               in_valid = 1'b1;
               in_a     = pa[i];
               in_b     = pb[i];
               for (int t = 0; t < 40 && !in_ready; t++) @(negedge clk);
               check("skid_accept", in_ready, 1);
               @(posedge clk);
               #1;
            end
            in_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 3; i++) begin
               watch_op(mres, mgap);
               check("skid_result", mres, er[i]);
               if (i > 0) check("skid_no_idle", mgap, 1);
            end
         end
      join
      @(negedge clk);
      check("skid_idle", {in_ready, busy}, 2'b10);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
